rr_onehot_arbiter: RTL and testbench

//  Upstream stage of the 8x3 one-hot-to-binary encoder. Collects multi-hot request

---
 rtl/rr_onehot_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter feeding the one-hot-to-binary encoder: latches multi-hot
// requests as pending and offers exactly one one-hot grant at a time over valid/ready.
module rr_onehot_arbiter #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic [N-1:0] gnt_onehot,
  output logic         gnt_valid,
  output logic [N-1:0] pending,
  output logic         coalesce
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  gnt_nxt;
  logic          valid_nxt;
  logic          acc;
  logic [N-1:0]  cleared;
  logic [N-1:0]  cand;
  logic [N-1:0]  winner;

  // First set bit of c, scanning upward from p and wrapping past N-1 to 0.
  function automatic logic [N-1:0] pick_rr(input logic [N-1:0] c, input logic [PW-1:0] p);
    logic [N-1:0] w;
    logic         found;
    int           j;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(p) + i) % N;
      if (!found && c[j]) begin
        w[j]  = 1'b1;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    return (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
  endfunction

  assign acc     = gnt_valid & gnt_ready;
  assign cleared = acc ? gnt_onehot : '0;
  // The bit being accepted is removed before selection; this cycle's req is not yet visible.
  assign cand    = pending & ~cleared;
  assign winner  = pick_rr(cand, ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_onehot <= '0;
      gnt_valid  <= 1'b0;
      ptr        <= '0;
      pending    <= '0;
      coalesce   <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_onehot <= gnt_nxt;
      gnt_valid  <= valid_nxt;
      ptr        <= ptr_nxt;
      // Set wins over clear: a req on the bit being accepted keeps it pending.
      pending    <= cand | req;
      coalesce   <= |(req & cand);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cand != '0) state_nxt = OFFER;
      OFFER:   if (acc && (cand == '0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt   = gnt_onehot;
    valid_nxt = gnt_valid;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        gnt_nxt   = winner;
        valid_nxt = (cand != '0);
      end
      OFFER: begin
        if (acc) begin
          ptr_nxt   = ptr_after(onehot_idx(gnt_onehot));
          gnt_nxt   = winner;
          valid_nxt = (cand != '0);
        end
      end
      default: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  a_onehot0: assert property (@(posedge clk) $onehot0(gnt_onehot));
  a_gnt_pending: assert property (@(posedge clk) gnt_valid |-> ((gnt_onehot & ~pending) == '0));
  a_idle_zero: assert property (@(posedge clk) !gnt_valid |-> (gnt_onehot == '0));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed scenarios with a queue of expected grants
// popped as each grant is accepted.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       gnt_ready;
  logic [7:0] gnt_onehot;
  logic       gnt_valid;
  logic [7:0] pending;
  logic       coalesce;

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic [7:0] exp_g;

  rr_onehot_arbiter #(.N(8), .PW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_onehot (gnt_onehot),
    .gnt_valid  (gnt_valid),
    .pending    (pending),
    .coalesce   (coalesce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 8'hFF;
    gnt_ready = 1'b1;
    tick();
    tick();
    total++;
    if ({gnt_onehot, gnt_valid, pending, coalesce} !== 18'h0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b/%h/%b exp=00/0/00/0", gnt_onehot, gnt_valid, pending, coalesce);
    end
    rst_n = 1'b1;
    req   = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({gnt_onehot, gnt_valid, pending, coalesce} !== 18'h0) begin
        bad++;
        $display("FAIL post_reset_idle got=%h/%b/%h/%b exp=00/0/00/0", gnt_onehot, gnt_valid, pending, coalesce);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req       = 8'h04;
    gnt_ready = 1'b1;
    tick();
    exp_q.push_back(8'h04);
    req = '0;
    total++;
    if (pending !== 8'h04 || gnt_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pending got=%h/%b exp=04/0", pending, gnt_valid);
    end
    tick();
    total++;
    if (gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_latency got=%b exp=1", gnt_valid);
    end
    if (gnt_valid && gnt_ready) begin
      exp_g = exp_q.pop_front();
      total++;
      if (gnt_onehot !== exp_g) begin
        bad++;
        $display("FAIL single_gnt got=%h exp=%h", gnt_onehot, exp_g);
      end
    end
    tick();
    total++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00 || pending !== 8'h00) begin
      bad++;
      $display("FAIL single_drop got=%h/%b/%h exp=00/0/00", gnt_onehot, gnt_valid, pending);
    end
  endtask

  task automatic test_pair();
    do_reset();
    req       = 8'h81;
    gnt_ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    tick();
    req = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (!gnt_valid || exp_q.size() == 0) begin
        bad++;
        $display("FAIL pair_consecutive got=valid%b exp=valid1 cycle=%0d", gnt_valid, c);
      end else begin
        exp_g = exp_q.pop_front();
        if (gnt_onehot !== exp_g) begin
          bad++;
          $display("FAIL pair_gnt got=%h exp=%h", gnt_onehot, exp_g);
        end
      end
    end
    tick();
    total++;
    if (gnt_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL pair_end got=valid%b left%0d exp=valid0 left0", gnt_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] one;
    do_reset();
    one = 8'h01;
    for (int i = 0; i < 16; i++) exp_q.push_back(one << (i % 8));
    req       = 8'hFF;
    gnt_ready = 1'b1;
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      total++;
      if (!gnt_valid || exp_q.size() == 0) begin
        bad++;
        $display("FAIL wrap_gap got=valid%b exp=valid1 cycle=%0d", gnt_valid, c);
      end else begin
        exp_g = exp_q.pop_front();
        if (gnt_onehot !== exp_g) begin
          bad++;
          $display("FAIL wrap_order got=%h exp=%h cycle=%0d", gnt_onehot, exp_g, c);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req       = 8'h30;
    gnt_ready = 1'b0;
    tick();
    req = '0;
    tick();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    for (int i = 0; i < 5; i++) begin
      req = (i == 1) ? 8'h20 : 8'h00;
      tick();
      total++;
      if (gnt_valid !== 1'b1 || gnt_onehot !== exp_q[0]) begin
        bad++;
        $display("FAIL hold_stable got=%h/%b exp=%h/1", gnt_onehot, gnt_valid, exp_q[0]);
      end
      total++;
      if (coalesce !== (i == 1)) begin
        bad++;
        $display("FAIL coalesce_pulse got=%b exp=%b cycle=%0d", coalesce, (i == 1), i);
      end
    end
    req       = '0;
    gnt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (gnt_valid && gnt_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bp_extra got=%h exp=none", gnt_onehot);
        end else begin
          exp_g = exp_q.pop_front();
          if (gnt_onehot !== exp_g) begin
            bad++;
            $display("FAIL bp_order got=%h exp=%h", gnt_onehot, exp_g);
          end
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0 || gnt_valid !== 1'b0 || pending !== 8'h00) begin
      bad++;
      $display("FAIL bp_drain got=left%0d/%b/%h exp=left0/0/00", exp_q.size(), gnt_valid, pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req       = 8'h08;
    gnt_ready = 1'b1;
    tick();
    req = '0;
    tick();
    tick();
    gnt_ready = 1'b0;
    req       = 8'h06;
    tick();
    req = '0;
    tick();
    total++;
    if (gnt_onehot !== 8'h02 || gnt_valid !== 1'b1 || pending !== 8'h06) begin
      bad++;
      $display("FAIL mid_setup got=%h/%b/%h exp=02/1/06", gnt_onehot, gnt_valid, pending);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({gnt_onehot, gnt_valid, pending, coalesce} !== 18'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%b/%h/%b exp=00/0/00/0", gnt_onehot, gnt_valid, pending, coalesce);
    end
    rst_n     = 1'b1;
    req       = 8'h11;
    gnt_ready = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h10);
    tick();
    req = '0;
    for (int c = 0; c < 6; c++) begin
      if (gnt_valid && gnt_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL mid_extra got=%h exp=none", gnt_onehot);
        end else begin
          exp_g = exp_q.pop_front();
          if (gnt_onehot !== exp_g) begin
            bad++;
            $display("FAIL mid_ptr_restart got=%h exp=%h", gnt_onehot, exp_g);
          end
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_missing got=left%0d exp=left0", exp_q.size());
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req       = '0;
    gnt_ready = 1'b0;
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
